// File: rtl/bcd_stream_sched.sv
// Two-requester round-robin scheduler feeding a BCD digit serialiser.
// Ports: clk/rst_n; reqN_valid/reqN_num/reqN_ready per requester;
// out_valid/out_ready/out_digit/out_last/out_src stream; busy,
// frame_done/frame_err status. Define BCD_ASCII_OUT_EN for ASCII digits.
module bcd_stream_sched #(
  parameter int NDIG = 11,
  parameter int GAP  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [4*NDIG-1:0] req0_num,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [4*NDIG-1:0] req1_num,
  output logic              req1_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_digit,
  output logic              out_last,
  output logic              out_src,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err
);

  localparam int W  = 4 * NDIG;
  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT,
    DONE
  } state_e;

  state_e        state_q;
  logic [W-1:0]  shift_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    gap_q;
  logic          rr_q;
  logic          src_q;
  logic          err_q;

  logic       idle;
  logic       gnt0;
  logic       gnt1;
  logic       bad;
  logic [3:0] nib;
  logic [7:0] enc;

  assign idle = (state_q == IDLE);

  // Contention goes to the requester the pointer names.
  assign gnt0 = req0_valid && (!req1_valid || !rr_q);
  assign gnt1 = req1_valid && (!req0_valid || rr_q);

  assign req0_ready = idle && gnt0;
  assign req1_ready = idle && gnt1;

  assign nib = shift_q[3:0];
  assign bad = (nib > 4'd9);

`ifdef BCD_ASCII_OUT_EN
  assign enc = bad ? 8'h3F : (8'h30 + {4'h0, nib});
`else
  assign enc = bad ? 8'hFF : {4'h0, nib};
`endif

  assign out_valid  = (state_q == SEND);
  assign out_digit  = out_valid ? enc : 8'h00;
  assign out_last   = out_valid && (cnt_q == LAST);
  assign out_src    = src_q;
  assign busy       = !idle;
  assign frame_done = (state_q == DONE);
  assign frame_err  = (state_q == DONE) && err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      rr_q    <= 1'b0;
      src_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req0_valid || req1_valid) begin
            shift_q <= gnt1 ? req1_num : req0_num;
            src_q   <= gnt1;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rr_q    <= ~gnt1;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            err_q   <= err_q | bad;
            shift_q <= shift_q >> 4;
            // Counter parks on the last index; no wrap.
            if (cnt_q == LAST) begin
              state_q <= DONE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
              if (GAP > 0) begin
                gap_q   <= 4'(GAP);
                state_q <= WAIT;
              end
            end
          end
        end
        WAIT: begin
          gap_q <= gap_q - 4'd1;
          if (gap_q <= 4'd1) begin
            state_q <= SEND;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_stream_sched.sv
// Directed + randomized bench for bcd_stream_sched.
// Checks against a digit-level frame model and a round-robin model.
module tb_bcd_stream_sched;

  localparam int NDIG = 11;
  localparam int W    = 4 * NDIG;

  logic         clk = 1'b0;
  logic         rst_n;

  logic         r0v, r1v, r0r, r1r;
  logic [W-1:0] r0n, r1n;
  logic         ov, ordy, ol, os, bsy, fd, fe;
  logic [7:0]   od;

  logic         g0v, g1v, g0r, g1r;
  logic [W-1:0] g0n, g1n;
  logic         gov, grdy, gol, gos, gbsy, gfd, gfe;
  logic [7:0]   god;

  int errors = 0;
  int checks = 0;
  bit rr;
  bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  always #5 clk = ~clk;

  bcd_stream_sched #(.NDIG(NDIG), .GAP(0)) u0 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(r0v), .req0_num(r0n), .req0_ready(r0r),
    .req1_valid(r1v), .req1_num(r1n), .req1_ready(r1r),
    .out_valid(ov), .out_ready(ordy), .out_digit(od),
    .out_last(ol), .out_src(os), .busy(bsy),
    .frame_done(fd), .frame_err(fe)
  );

  bcd_stream_sched #(.NDIG(NDIG), .GAP(2)) u2 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(g0v), .req0_num(g0n), .req0_ready(g0r),
    .req1_valid(g1v), .req1_num(g1n), .req1_ready(g1r),
    .out_valid(gov), .out_ready(grdy), .out_digit(god),
    .out_last(gol), .out_src(gos), .busy(gbsy),
    .frame_done(gfd), .frame_err(gfe)
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_byte(input int n);
`ifdef BCD_ASCII_OUT_EN
    return (n > 9) ? 8'h3F : 8'(48 + n);
`else
    return (n > 9) ? 8'hFF : 8'(n);
`endif
  endfunction

  function automatic logic [W-1:0] rnum(input bit allow_bad);
    logic [W-1:0] n;
    n = '0;
    for (int i = 0; i < NDIG; i++) begin
      n = n << 4;
      if (allow_bad && ($urandom % 5 == 0))
        n[3:0] = 4'($urandom_range(10, 15));
      else
        n[3:0] = 4'($urandom_range(0, 9));
    end
    return n;
  endfunction

  function automatic bit pick(input int mode, input int c);
    if (mode == 1) return pat[c % 4];
    if (mode == 2) return (c > 200) || ($urandom % 3 != 0);
    return 1'b1;
  endfunction

  task automatic do_reset();
    r0v = 0; r1v = 0; g0v = 0; g1v = 0;
    rst_n = 0;
    tick();
    rst_n = 1;
    tick();
    rr = 0;
  endtask

  // One frame on u0: handshake, NDIG digits, done. abort>=0 resets
  // asynchronously while digit 'abort' is being offered.
  task automatic frame(input bit v0, input logic [W-1:0] n0,
                       input bit v1, input logic [W-1:0] n1,
                       input int mode, input int abort);
    int g, c, nib;
    bit err, rdy;
    logic [W-1:0] num, tmp;
    g = (v0 && v1) ? int'(rr) : (v1 ? 1 : 0);
    num = g ? n1 : n0;
    r0v = v0; r0n = n0; r1v = v1; r1n = n1;
    #1;
    check("req0_ready", r0r, g == 0);
    check("req1_ready", r1r, g == 1);
    rr = (g == 0);
    tick();
    if (g == 0) r0v = 0; else r1v = 0;
    err = 0;
    c = 0;
    for (int k = 0; k < NDIG; k++) begin
      tmp = num >> (4 * k);
      nib = int'(tmp[3:0]);
      err |= (nib > 9);
      if (k == abort) begin
        r0v = 0; r1v = 0;
        rst_n = 0;
        #1;
        check("rst out_valid", ov, 0);
        check("rst out_digit", od, 0);
        check("rst out_last", ol, 0);
        check("rst out_src", os, 0);
        check("rst busy", bsy, 0);
        check("rst frame_done", fd, 0);
        check("rst frame_err", fe, 0);
        tick();
        check("rst hold done", fd, 0);
        rst_n = 1;
        tick();
        check("post rst done", fd, 0);
        rr = 0;
        return;
      end
      do begin
        rdy = pick(mode, c);
        c++;
        ordy = rdy;
        #1;
        check("out_valid", ov, 1);
        check("out_digit", od, exp_byte(nib));
        check("out_last", ol, k == NDIG - 1);
        check("out_src", os, g);
        check("ready0 busy", r0r, 0);
        check("ready1 busy", r1r, 0);
        check("done early", fd, 0);
        tick();
      end while (!rdy);
    end
    ordy = $urandom_range(0, 1);
    #1;
    check("frame_done", fd, 1);
    check("frame_err", fe, err);
    check("valid in done", ov, 0);
    tick();
    #1;
    check("done pulse", fd, 0);
    check("idle busy", bsy, 0);
  endtask

  initial begin
    int v0, v1;
    logic [W-1:0] gn, tmp;
    bit gerr;
    rst_n = 0;
    r0v = 0; r1v = 0; r0n = '0; r1n = '0; ordy = 0;
    g0v = 0; g1v = 0; g0n = '0; g1n = '0; grdy = 0;
    rr = 0;
    #3;
    check("reset out_valid", ov, 0);
    check("reset out_digit", od, 0);
    check("reset out_last", ol, 0);
    check("reset out_src", os, 0);
    check("reset busy", bsy, 0);
    check("reset frame_done", fd, 0);
    check("reset frame_err", fe, 0);
    check("reset ready0", r0r, 0);
    #14;
    rst_n = 1;
    tick();

    frame(1, 44'h13912345678, 0, '0, 0, -1);

    do_reset();
    frame(1, {NDIG{4'h1}}, 1, {NDIG{4'h2}}, 0, -1);
    frame(1, {NDIG{4'h1}}, 1, {NDIG{4'h2}}, 0, -1);

    frame(1, rnum(0), 0, '0, 1, -1);

    frame(0, '0, 1, 44'h9876543A210, 0, -1);
    frame(1, rnum(0), 0, '0, 0, -1);

    for (int i = 0; i < 8; i++) begin
      v0 = $urandom_range(0, 1);
      v1 = (v0 == 0) ? 1 : $urandom_range(0, 1);
      frame(v0[0], rnum(1), v1[0], rnum(1), 2, -1);
    end

    frame(1, rnum(0), 0, '0, 0, 5);
    frame(0, '0, 1, rnum(0), 0, -1);
    r0v = 0; r1v = 0;

    gn = rnum(1);
    gerr = 0;
    grdy = 1;
    g0v = 1; g0n = gn;
    #1;
    check("gap ready0", g0r, 1);
    tick();
    g0v = 0;
    for (int k = 0; k < NDIG; k++) begin
      tmp = gn >> (4 * k);
      gerr |= (tmp[3:0] > 4'd9);
      #1;
      check("gap valid", gov, 1);
      check("gap digit", god, exp_byte(int'(tmp[3:0])));
      check("gap last", gol, k == NDIG - 1);
      tick();
      if (k < NDIG - 1) begin
        repeat (2) begin
          #1;
          check("gap idle", gov, 0);
          tick();
        end
      end
    end
    #1;
    check("gap done", gfd, 1);
    check("gap err", gfe, gerr);
    tick();
    #1;
    check("gap done pulse", gfd, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
